// File: rtl/pipe_hazard_ctrl_if.sv
// rtl/pipe_hazard_ctrl_if.sv - pipeline-side signal bundle for the hazard controller
interface pipe_hazard_ctrl_if;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic        id_uses_rt;
    logic [4:0]  rr_rt;
    logic        rr_memread;
    logic        rr_jump;
    logic        mem_busy;
    logic        pc_en;
    logic        ifid_en;
    logic        ifid_flush;
    logic        idrr_en;
    logic        idrr_bubble;
    logic [1:0]  state;
    logic [15:0] stall_count;

    modport master (
        output id_rs, id_rt, id_uses_rt, rr_rt, rr_memread, rr_jump, mem_busy,
        input  pc_en, ifid_en, ifid_flush, idrr_en, idrr_bubble, state, stall_count
    );

    modport slave (
        input  id_rs, id_rt, id_uses_rt, rr_rt, rr_memread, rr_jump, mem_busy,
        output pc_en, ifid_en, ifid_flush, idrr_en, idrr_bubble, state, stall_count
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - load-use stall, jump flush and memory-wait freeze control
module pipe_hazard_ctrl #(
    parameter int LOAD_STALL = 2
) (
    input  logic               clk,
    input  logic               rst,
    pipe_hazard_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {
        ST_RUN   = 2'b00,
        ST_STALL = 2'b01,
        ST_FLUSH = 2'b10
    } state_e;

    // The hazard cycle in RUN is the first bubble, so STALL covers the rest.
    localparam logic [1:0] CNT_INIT = (LOAD_STALL >= 2) ? 2'(LOAD_STALL - 2) : 2'd0;

    state_e      state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [15:0] stall_count_q, stall_count_d;
    state_e      state_eff;
    logic        hazard;
    logic        pc_en, ifid_en, ifid_flush, idrr_en, idrr_bubble;

    // Load in ID/RR writing a register the decode instruction reads; r0 never hazards.
    always_comb begin
        hazard = bus.rr_memread && (bus.rr_rt != 5'd0) &&
                 ((bus.rr_rt == bus.id_rs) || (bus.id_uses_rt && (bus.rr_rt == bus.id_rt)));
    end

    // Output decode and next-state; reset forces RUN decoding so bubbles are abandoned.
    always_comb begin
        state_eff   = rst ? ST_RUN : state_q;
        state_d     = state_q;
        cnt_d       = cnt_q;
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        ifid_flush  = 1'b0;
        idrr_en     = 1'b1;
        idrr_bubble = 1'b0;
        if (bus.mem_busy) begin
            pc_en   = 1'b0;
            ifid_en = 1'b0;
            idrr_en = 1'b0;
        end else begin
            case (state_eff)
                ST_STALL: begin
                    pc_en       = 1'b0;
                    ifid_en     = 1'b0;
                    idrr_bubble = 1'b1;
                    if (cnt_q == 2'd0) begin
                        state_d = ST_RUN;
                    end else begin
                        cnt_d = cnt_q - 2'd1;
                    end
                end
                ST_FLUSH: begin
                    state_d = ST_RUN;
                end
                default: begin
                    if (bus.rr_jump) begin
                        ifid_flush  = 1'b1;
                        idrr_bubble = 1'b1;
                        state_d     = ST_FLUSH;
                    end else if (hazard) begin
                        pc_en       = 1'b0;
                        ifid_en     = 1'b0;
                        idrr_bubble = 1'b1;
                        if (LOAD_STALL > 1) begin
                            state_d = ST_STALL;
                            cnt_d   = CNT_INIT;
                        end else begin
                            state_d = ST_RUN;
                        end
                    end else begin
                        state_d = ST_RUN;
                    end
                end
            endcase
        end
        stall_count_d = stall_count_q;
        if (!pc_en && (stall_count_q != 16'hFFFF)) begin
            stall_count_d = stall_count_q + 16'd1;
        end
    end

    // State, bubble counter and stall statistic registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_RUN;
            cnt_q         <= 2'd0;
            stall_count_q <= 16'd0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            stall_count_q <= stall_count_d;
        end
    end

    // Drive the bundle.
    always_comb begin
        bus.pc_en       = pc_en;
        bus.ifid_en     = ifid_en;
        bus.ifid_flush  = ifid_flush;
        bus.idrr_en     = idrr_en;
        bus.idrr_bubble = idrr_bubble;
        bus.state       = state_q;
        bus.stall_count = stall_count_q;
    end
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - directed table, corner sequences and random model check
module tb_pipe_hazard_ctrl;
    localparam int LS = 2;

    logic clk;
    logic rst;
    int   errors;
    int   checks;

    pipe_hazard_ctrl_if bus ();

    pipe_hazard_ctrl #(.LOAD_STALL(LS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic        uses_rt;
        logic [4:0]  rr_rt;
        logic        memread;
        logic        jump;
        logic        busy;
        logic [4:0]  outs;   // {pc_en, ifid_en, ifid_flush, idrr_en, idrr_bubble}
        logic [1:0]  st;
        logic [15:0] sc;
    } vec_t;

    localparam logic [4:0] O_RUN   = 5'b11010;
    localparam logic [4:0] O_STALL = 5'b00011;
    localparam logic [4:0] O_JUMP  = 5'b11111;
    localparam logic [4:0] O_BUSY  = 5'b00000;

    vec_t rows [26];

    // Model state: bubbles still owed, flush cycle pending, stall statistic.
    int   m_pending;
    bit   m_flush;
    int   m_stalls;

    function automatic vec_t mk(logic r, logic [4:0] rs, logic [4:0] rt, logic u,
                                logic [4:0] rrt, logic mr, logic j, logic b,
                                logic [4:0] o, logic [1:0] st, logic [15:0] sc);
        vec_t v;
        v.rst = r; v.rs = rs; v.rt = rt; v.uses_rt = u; v.rr_rt = rrt;
        v.memread = mr; v.jump = j; v.busy = b; v.outs = o; v.st = st; v.sc = sc;
        return v;
    endfunction

    function automatic logic [22:0] actual();
        return {bus.pc_en, bus.ifid_en, bus.ifid_flush, bus.idrr_en, bus.idrr_bubble,
                bus.state, bus.stall_count};
    endfunction

    task automatic check(input string name, input logic [22:0] act, input logic [22:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got outs=%b state=%b sc=%h, want outs=%b state=%b sc=%h",
                     name, act[22:18], act[17:16], act[15:0], exp[22:18], exp[17:16], exp[15:0]);
        end
    endtask

    task automatic drive(input vec_t v);
        rst            = v.rst;
        bus.id_rs      = v.rs;
        bus.id_rt      = v.rt;
        bus.id_uses_rt = v.uses_rt;
        bus.rr_rt      = v.rr_rt;
        bus.rr_memread = v.memread;
        bus.rr_jump    = v.jump;
        bus.mem_busy   = v.busy;
    endtask

    // Expected outputs for one cycle from the bubble/flush bookkeeping, then advance it.
    task automatic model_cycle(input vec_t v, output logic [22:0] exp);
        logic [4:0] o;
        logic [1:0] st;
        bit         hz;
        int         pend;
        bit         fl;
        hz   = v.memread && (v.rr_rt != 0) &&
               ((v.rr_rt == v.rs) || (v.uses_rt && (v.rr_rt == v.rt)));
        pend = v.rst ? 0 : m_pending;
        fl   = v.rst ? 1'b0 : m_flush;
        if (v.busy)          o = O_BUSY;
        else if (pend > 0)   o = O_STALL;
        else if (fl)         o = O_RUN;
        else if (v.jump)     o = O_JUMP;
        else if (hz)         o = O_STALL;
        else                 o = O_RUN;
        st  = (m_pending > 0) ? 2'b01 : (m_flush ? 2'b10 : 2'b00);
        exp = {o, st, 16'(m_stalls)};
        if (v.rst) begin
            m_pending = 0;
            m_flush   = 1'b0;
            m_stalls  = 0;
        end else begin
            if (!o[4] && m_stalls < 65535) m_stalls++;
            if (!v.busy) begin
                if (m_pending > 0)  m_pending--;
                else if (m_flush)   m_flush = 1'b0;
                else if (v.jump)    m_flush = 1'b1;
                else if (hz)        m_pending = LS - 1;
            end
        end
    endtask

    initial begin
        vec_t        idle;
        vec_t        v;
        logic [22:0] e;
        errors = 0;
        checks = 0;

        idle = mk(0, 5'd0, 5'd0, 0, 5'd0, 0, 0, 0, O_RUN, 2'd0, 16'd0);
        //            rst rs  rt  u  rrt mr j  b  outs     st  sc
        rows[0]  = mk(0, 1,  2,  0, 0,  0, 0, 0, O_RUN,   0, 0);
        rows[1]  = mk(0, 5,  0,  0, 5,  1, 0, 0, O_STALL, 0, 0);
        rows[2]  = mk(0, 5,  0,  0, 5,  1, 0, 0, O_STALL, 1, 1);
        rows[3]  = mk(0, 0,  0,  0, 0,  0, 0, 0, O_RUN,   0, 2);
        rows[4]  = mk(0, 0,  0,  0, 0,  1, 0, 0, O_RUN,   0, 2);
        rows[5]  = mk(0, 1,  7,  0, 7,  1, 0, 0, O_RUN,   0, 2);
        rows[6]  = mk(0, 1,  7,  1, 7,  1, 0, 0, O_STALL, 0, 2);
        rows[7]  = mk(0, 0,  0,  0, 0,  0, 0, 0, O_STALL, 1, 3);
        rows[8]  = mk(0, 0,  0,  0, 0,  0, 0, 0, O_RUN,   0, 4);
        rows[9]  = mk(0, 3,  0,  0, 3,  1, 1, 0, O_JUMP,  0, 4);
        rows[10] = mk(0, 3,  0,  0, 3,  1, 0, 0, O_RUN,   2, 4);
        rows[11] = mk(0, 0,  0,  0, 0,  0, 0, 0, O_RUN,   0, 4);
        rows[12] = mk(0, 5,  0,  0, 5,  1, 0, 0, O_STALL, 0, 4);
        rows[13] = mk(0, 0,  0,  0, 0,  0, 0, 1, O_BUSY,  1, 5);
        rows[14] = mk(0, 0,  0,  0, 0,  0, 0, 1, O_BUSY,  1, 6);
        rows[15] = mk(0, 0,  0,  0, 0,  0, 0, 1, O_BUSY,  1, 7);
        rows[16] = mk(0, 0,  0,  0, 0,  0, 0, 0, O_STALL, 1, 8);
        rows[17] = mk(0, 0,  0,  0, 0,  0, 0, 0, O_RUN,   0, 9);
        rows[18] = mk(0, 5,  0,  0, 5,  1, 0, 0, O_STALL, 0, 9);
        rows[19] = mk(1, 0,  0,  0, 0,  0, 0, 0, O_RUN,   1, 10);
        rows[20] = mk(0, 0,  0,  0, 0,  0, 0, 0, O_RUN,   0, 0);
        rows[21] = mk(0, 0,  0,  0, 0,  0, 1, 0, O_JUMP,  0, 0);
        rows[22] = mk(1, 0,  0,  0, 0,  0, 0, 0, O_RUN,   2, 0);
        rows[23] = mk(0, 0,  0,  0, 0,  0, 0, 0, O_RUN,   0, 0);
        rows[24] = mk(0, 0,  0,  0, 0,  0, 1, 1, O_BUSY,  0, 0);
        rows[25] = mk(0, 0,  0,  0, 0,  0, 0, 0, O_RUN,   0, 1);

        // Initial reset, registered values unknown until it lands.
        v = idle; v.rst = 1'b1;
        drive(v);
        @(posedge clk); @(posedge clk); #1;

        for (int i = 0; i < 26; i++) begin
            drive(rows[i]);
            #2;
            check($sformatf("row%0d", i), actual(), {rows[i].outs, rows[i].st, rows[i].sc});
            @(posedge clk); #1;
        end

        // Saturation: clear the statistic, then hold memory busy past 65536 cycles.
        v = idle; v.rst = 1'b1;
        drive(v);
        @(posedge clk); #1;
        v = idle; v.busy = 1'b1;
        drive(v);
        for (int i = 0; i < 65537; i++) begin
            @(posedge clk);
        end
        #2;
        check("sat_busy", actual(), {O_BUSY, 2'b00, 16'hFFFF});
        @(posedge clk); #1;
        drive(idle);
        #2;
        check("sat_hold", actual(), {O_RUN, 2'b00, 16'hFFFF});
        v = idle; v.rs = 5'd9; v.rr_rt = 5'd9; v.memread = 1'b1;
        drive(v);
        #1;
        check("sat_hazard", actual(), {O_STALL, 2'b00, 16'hFFFF});
        @(posedge clk); #1;
        drive(idle);
        #2;
        check("sat_stall", actual(), {O_STALL, 2'b01, 16'hFFFF});
        @(posedge clk); #1;

        // Random traffic against the bookkeeping model, starting from the known saturated RUN state.
        m_pending = 0;
        m_flush   = 1'b0;
        m_stalls  = 65535;
        for (int i = 0; i < 3000; i++) begin
            v         = idle;
            v.rst     = ($urandom_range(0, 59) == 0);
            v.rs      = 5'($urandom_range(0, 3));
            v.rt      = 5'($urandom_range(0, 3));
            v.uses_rt = 1'($urandom_range(0, 1));
            v.rr_rt   = 5'($urandom_range(0, 3));
            v.memread = ($urandom_range(0, 2) != 0);
            v.jump    = ($urandom_range(0, 5) == 0);
            v.busy    = ($urandom_range(0, 7) == 0);
            drive(v);
            #2;
            model_cycle(v, e);
            check($sformatf("rand%0d", i), actual(), e);
            @(posedge clk); #1;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 Parameter LOAD_STALL, default 2, number of bubble cycles inserted per load-use hazard (legal 1..3).
REQ-002 clk  in  1  rising-edge clock for all state.
REQ-003 rst  in  1  synchronous, active-high reset, sampled on rising clk edge.
REQ-004 id_rs  in  5  rs field of instruction in decode (IF/ID output).
REQ-005 id_rt  in  5  rt field of instruction in decode.
REQ-006 id_uses_rt  in  1  decode instruction reads rt as a source (R-type, beq, sw).
REQ-007 rr_rt  in  5  rt of instruction held in ID/RR register.
REQ-008 rr_memread  in  1  MemRead of instruction held in ID/RR register.
REQ-009 rr_jump  in  1  Jump of instruction held in ID/RR register.
REQ-010 mem_busy  in  1  data memory wait; freezes whole front end.
REQ-011 pc_en  out  1  PC register load enable.
REQ-012 ifid_en  out  1  IF/ID register load enable.
REQ-013 ifid_flush  out  1  IF/ID loads a NOP (all-zero instruction).
REQ-014 idrr_en  out  1  ID/RR register load enable.
REQ-015 idrr_bubble  out  1  ID/RR loads all control signals (RegWrite, MemRead, MemWrite, Jump, etc.) as 0.
REQ-016 state  out  2  FSM state: 00 RUN, 01 STALL, 10 FLUSH.
REQ-017 stall_count  out  16  saturating count of cycles with pc_en=0.

Function
REQ-018 Hazard SHALL be: rr_memread=1 AND rr_rt!=0 AND (rr_rt==id_rs OR (id_uses_rt=1 AND rr_rt==id_rt)).
REQ-019 Register 0 SHALL never cause a hazard.
REQ-020 States: RUN, STALL, FLUSH; 2-bit down-counter cnt used only in STALL.
REQ-021 RUN, no hazard, rr_jump=0: pc_en=1, ifid_en=1, idrr_en=1, ifid_flush=0, idrr_bubble=0; stay RUN.
REQ-022 RUN, rr_jump=1: same cycle ifid_flush=1, idrr_bubble=1, pc_en=1, ifid_en=1, idrr_en=1; next state FLUSH.
REQ-023 rr_jump SHALL take priority over a simultaneous hazard (hazard ignored that cycle).
REQ-024 RUN, hazard, rr_jump=0: same cycle pc_en=0, ifid_en=0, idrr_en=1, idrr_bubble=1; if LOAD_STALL=1 stay RUN, else next state STALL with cnt=LOAD_STALL-2.
REQ-025 STALL: pc_en=0, ifid_en=0, idrr_en=1, idrr_bubble=1; hazard and rr_jump inputs ignored; cnt=0 -> RUN, else cnt decrements.
REQ-026 Total consecutive bubble cycles per hazard SHALL equal LOAD_STALL exactly.
REQ-027 FLUSH: one cycle; all enables 1, ifid_flush=0, idrr_bubble=0, hazard/jump not evaluated; next state RUN.
REQ-028 mem_busy=1 SHALL override all: pc_en=0, ifid_en=0, idrr_en=0, ifid_flush=0, idrr_bubble=0; state and cnt held.
REQ-029 stall_count increments by 1 each cycle pc_en=0 (including mem_busy), saturating at 16'hFFFF.
REQ-030 All outputs other than state/stall_count are combinational from state, cnt and inputs; no other latency.

Reset
REQ-031 rst=1 at a clock edge SHALL set state=RUN, cnt=0, stall_count=0, regardless of current state or mem_busy.
REQ-032 During and immediately after reset, outputs follow RUN decoding of current inputs; reset mid-STALL aborts remaining bubbles.

Verification
REQ-033 Load-use: rr_memread=1, rr_rt=5, id_rs=5, LOAD_STALL=2 -> pc_en=0 and idrr_bubble=1 for exactly 2 cycles, state 00->01->00, stall_count=2.
REQ-034 No false hazard: rr_memread=1, rr_rt=0, id_rs=0 -> pc_en stays 1; also rr_rt=7, id_rt=7, id_uses_rt=0 -> no stall.
REQ-035 Jump+hazard same cycle: rr_jump=1, rr_memread=1, rr_rt=id_rs=3 -> ifid_flush=1, idrr_bubble=1, pc_en=1, state->10 then 00, stall_count unchanged.
REQ-036 mem_busy mid-stall: hazard, then mem_busy=1 for 3 cycles in STALL -> all enables 0, state held 01; after release, 1 remaining bubble cycle, stall_count=5.
REQ-037 Reset mid-stall: rst=1 in STALL with stall_count=4 -> next cycle state=00, stall_count=0, pc_en=1 if no hazard.
REQ-038 Saturation: force 65537 mem_busy cycles -> stall_count holds 16'hFFFF.
